list_loader: RTL and testbench

- Writer-side front end for the two-list comparison datapath.
- Consumes an ASCII byte stream of puzzle input, one pair per line in the form "<left><spaces><right>\n".
- Parses each line into two unsigned 32-bit decimal values and writes the left value to list memory 1 and the right value to list memory 2 at the same incrementing address.
- Reports the pair count on `length` and pulses nothing at completion: it raises `done` when the stream ends, which hands off to the summing engine.

---
 rtl/list_loader_pkg.sv | 46 ++++
 rtl/list_loader_if.sv | 40 ++++
 rtl/list_loader_dec_accum.sv | 42 ++++
 rtl/list_loader.sv | 185 ++++++++++++++++++
 tb/tb_list_loader.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/list_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : list_pkg
//  Purpose  : Shared types, ASCII constants and byte classification for the
//             list loader (parser FSM state encoding, character classes).
//  Revision : 1.0  initial release
// ============================================================================
package list_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LSTART = 3'd1,
    LEFT   = 3'd2,
    GAP    = 3'd3,
    RIGHT  = 3'd4,
    TAIL   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } loader_state_t;

  typedef enum logic [1:0] {
    CLS_DIG = 2'd0,
    CLS_SP  = 2'd1,
    CLS_LF  = 2'd2,
    CLS_BAD = 2'd3
  } byte_class_t;

  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_TAB = 8'h09;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_0   = 8'h30;
  localparam logic [7:0] CH_9   = 8'h39;

  // CR is folded into the whitespace class so CRLF line endings parse cleanly.
  function automatic byte_class_t classify(input logic [7:0] b);
    byte_class_t cls;
    if (b >= CH_0 && b <= CH_9)                   cls = CLS_DIG;
    else if (b == CH_SP || b == CH_TAB || b == CH_CR) cls = CLS_SP;
    else if (b == CH_LF)                          cls = CLS_LF;
    else                                          cls = CLS_BAD;
    return cls;
  endfunction

endpackage
`default_nettype wire

// File: rtl/list_loader_if.sv
`default_nettype none
// ============================================================================
//  Module   : list_loader_if
//  Purpose  : Byte-stream input and dual list-memory write bus of the loader.
//  Ports    : go/in_* from the stream source; in_ready back; we/addr/data for
//             both list memories; length/done/error status.
//             master = stream source / memory sink side, slave = loader.
//  Revision : 1.0  initial release
// ============================================================================
interface list_loader_if #(
  parameter int ADDR_W = 32
);
  logic              go;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_last;
  logic              in_ready;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [31:0]       data1_in;
  logic              we2;
  logic [ADDR_W-1:0] addr2;
  logic [31:0]       data2_in;
  logic [15:0]       length;
  logic              done;
  logic              error;

  modport master (
    output go, in_data, in_valid, in_last,
    input  in_ready, we1, addr1, data1_in, we2, addr2, data2_in,
           length, done, error
  );

  modport slave (
    input  go, in_data, in_valid, in_last,
    output in_ready, we1, addr1, data1_in, we2, addr2, data2_in,
           length, done, error
  );
endinterface
`default_nettype wire

// File: rtl/list_loader_dec_accum.sv
`default_nettype none
// ============================================================================
//  Module   : dec_accum
//  Purpose  : 32-bit decimal accumulator shared by the left and right fields.
//  Ports    : clk, reset (async active-low); clear_i, load_i (first digit),
//             push_i (acc*10+digit), digit_i; acc_o value, ovf_o asserted
//             when a push of digit_i would exceed 2^32-1.
//  Revision : 1.0  initial release
// ============================================================================
module dec_accum (
  input  wire logic        clk,
  input  wire logic        reset,
  input  wire logic        clear_i,
  input  wire logic        load_i,
  input  wire logic        push_i,
  input  wire logic [3:0]  digit_i,
  output logic      [31:0] acc_o,
  output logic             ovf_o
);

  logic [31:0] acc_q;
  logic [35:0] next_w;

  // 36 bits hold (2^32-1)*10+9 without wrap, so the top nibble flags overflow.
  assign next_w = ({4'd0, acc_q} * 36'd10) + {32'd0, digit_i};
  assign ovf_o  = |next_w[35:32];
  assign acc_o  = acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= 32'd0;
    end else if (clear_i) begin
      acc_q <= 32'd0;
    end else if (load_i) begin
      acc_q <= {28'd0, digit_i};
    end else if (push_i && !ovf_o) begin
      acc_q <= next_w[31:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/list_loader.sv
`default_nettype none
// ============================================================================
//  Module   : list_loader
//  Purpose  : Parses "<left><spaces><right>\n" ASCII lines into 32-bit pairs
//             and writes them to two list memories at an incrementing address.
//  Ports    : clk, reset (async active-low), bus (list_loader_if.slave):
//             go/in_data/in_valid/in_last in, in_ready out, we1/addr1/
//             data1_in and we2/addr2/data2_in writes, length/done/error.
//  Revision : 1.0  initial release
// ============================================================================
module list_loader
  import list_pkg::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  list_loader_if.slave  bus
);

  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  loader_state_t state_q, state_d;
  logic          wr_pend_q, wr_pend_d;   // pair completed, write goes out next cycle
  logic          last_q, last_d;         // stream ended; finish after the pending write
  logic [31:0]   left_q, left_d;
  logic [15:0]   length_q, length_d;

  logic          acc_clear, acc_load, acc_push, acc_ovf;
  logic [31:0]   acc_w;
  logic          in_ready_w, we_w;
  byte_class_t   cls_w;

  dec_accum u_accum (
    .clk     (clk),
    .reset   (reset),
    .clear_i (acc_clear),
    .load_i  (acc_load),
    .push_i  (acc_push),
    .digit_i (bus.in_data[3:0]),
    .acc_o   (acc_w),
    .ovf_o   (acc_ovf)
  );

  assign cls_w = classify(bus.in_data);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      wr_pend_q <= 1'b0;
      last_q    <= 1'b0;
      left_q    <= 32'd0;
      length_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      wr_pend_q <= wr_pend_d;
      last_q    <= last_d;
      left_q    <= left_d;
      length_q  <= length_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_pend_d  = 1'b0;
    last_d     = last_q;
    left_d     = left_q;
    length_d   = length_q;
    acc_clear  = 1'b0;
    acc_load   = 1'b0;
    acc_push   = 1'b0;
    in_ready_w = 1'b0;
    we_w       = 1'b0;

    if (wr_pend_q) begin
      // Write cycle: input is stalled; the right value still sits in the accumulator.
      if (length_q == DEPTH16) begin
        state_d = ERR;
      end else begin
        we_w     = 1'b1;
        length_d = length_q + 16'd1;
        state_d  = last_q ? DONE : LSTART;
      end
    end else begin
      case (state_q)
        IDLE, DONE, ERR: begin
          if (bus.go) begin
            state_d   = LSTART;
            length_d  = 16'd0;
            left_d    = 32'd0;
            last_d    = 1'b0;
            acc_clear = 1'b1;
          end
        end
        default: begin
          in_ready_w = 1'b1;
          if (bus.in_valid) begin
            case (state_q)
              LSTART: begin
                if (cls_w == CLS_DIG) begin
                  state_d  = LEFT;
                  acc_load = 1'b1;
                end else if (cls_w == CLS_BAD) begin
                  state_d = ERR;
                end
              end
              LEFT: begin
                if (cls_w == CLS_DIG) begin
                  if (acc_ovf) state_d = ERR;
                  else         acc_push = 1'b1;
                end else if (cls_w == CLS_SP) begin
                  left_d  = acc_w;
                  state_d = GAP;
                end else begin
                  state_d = ERR;
                end
              end
              GAP: begin
                if (cls_w == CLS_DIG) begin
                  state_d  = RIGHT;
                  acc_load = 1'b1;
                end else if (cls_w != CLS_SP) begin
                  state_d = ERR;
                end
              end
              RIGHT: begin
                case (cls_w)
                  CLS_DIG: begin
                    if (acc_ovf) state_d = ERR;
                    else         acc_push = 1'b1;
                  end
                  CLS_SP:  state_d = TAIL;
                  CLS_LF: begin
                    wr_pend_d = 1'b1;
                    state_d   = LSTART;
                  end
                  default: state_d = ERR;
                endcase
              end
              TAIL: begin
                if (cls_w == CLS_LF) begin
                  wr_pend_d = 1'b1;
                  state_d   = LSTART;
                end else if (cls_w != CLS_SP) begin
                  state_d = ERR;
                end
              end
              default: ;
            endcase

            // End of stream is judged on the state the final byte produced.
            if (bus.in_last && state_d != ERR) begin
              case (state_d)
                LSTART: begin
                  if (wr_pend_d) last_d = 1'b1;
                  else           state_d = DONE;
                end
                LEFT, GAP: state_d = ERR;
                RIGHT, TAIL: begin
                  wr_pend_d = 1'b1;
                  last_d    = 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
      endcase
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.we1      = we_w;
  assign bus.we2      = we_w;
  assign bus.addr1    = ADDR_W'(length_q);
  assign bus.addr2    = ADDR_W'(length_q);
  assign bus.data1_in = left_q;
  assign bus.data2_in = acc_w;
  assign bus.length   = length_q;
  assign bus.done     = (state_q == DONE);
  assign bus.error    = (state_q == ERR);

endmodule
`default_nettype wire

// File: tb/tb_list_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_list_loader
//  Purpose  : Self-checking bench for list_loader: directed and random byte
//             streams, line-level reference model, write scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_list_loader;

  localparam int DEPTH = 2;
  localparam longint unsigned MAXV = 64'd4294967295;

  typedef struct {
    int unsigned addr;
    logic [31:0] d1;
    logic [31:0] d2;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  list_loader_if #(.ADDR_W(32)) bus ();

  list_loader #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  wr_t exp_q[$];
  logic [7:0] stim[$];
  int  exp_len;
  bit  exp_err;
  int  done_lat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference model: works line by line on whitespace-separated tokens.
  task automatic model_stream();
    int p, e, toks, nw;
    bit err, bad, in_tok, ovf;
    longint unsigned val;
    longint unsigned vals[2];
    logic [7:0] c;
    wr_t w;
    p = 0; nw = 0; err = 0;
    while (p < stim.size() && !err) begin
      e = p;
      while (e < stim.size() && stim[e] != 8'h0A) e++;
      toks = 0; bad = 0; in_tok = 0; ovf = 0; val = 0;
      vals[0] = 0; vals[1] = 0;
      for (int k = p; k < e; k++) begin
        c = stim[k];
        if (c >= 8'h30 && c <= 8'h39) begin
          if (!in_tok) begin in_tok = 1; val = 0; toks++; end
          val = val * 10 + longint'(c - 8'h30);
          if (val > MAXV) begin ovf = 1; val = MAXV + 1; end
          if (toks <= 2) vals[toks-1] = val;
        end else if (c == 8'h20 || c == 8'h09 || c == 8'h0D) begin
          in_tok = 0;
        end else begin
          bad = 1;
        end
      end
      if (bad || ovf || toks == 1 || toks > 2) begin
        err = 1;
      end else if (toks == 2) begin
        if (nw == DEPTH) err = 1;
        else begin
          w.addr = nw; w.d1 = vals[0][31:0]; w.d2 = vals[1][31:0];
          exp_q.push_back(w);
          nw++;
        end
      end
      p = e + 1;
    end
    exp_len = nw;
    exp_err = err;
  endtask

  task automatic load_str(input string s);
    stim.delete();
    for (int i = 0; i < s.len(); i++) stim.push_back(s.getc(i));
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    @(posedge clk); #1;
    bus.go = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit last, output bit ok);
    int n;
    ok = 0;
    if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    bus.in_data = b; bus.in_valid = 1'b1; bus.in_last = last;
    n = 0;
    while (!ok) begin
      @(negedge clk);
      if (bus.in_ready) begin @(posedge clk); #1; ok = 1; end
      else if (bus.error || n >= 50) break;
      n++;
    end
    if (!ok && !bus.error) check("byte_accept", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic run_stream();
    bit ok;
    model_stream();
    pulse_go();
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], (i == stim.size() - 1), ok);
      if (!ok) break;
    end
    done_lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (bus.done || bus.error) begin done_lat = n; break; end
    end
    check("done",   {63'd0, bus.done},  {63'd0, !exp_err});
    check("error",  {63'd0, bus.error}, {63'd0, exp_err});
    check("length", {48'd0, bus.length}, 64'(exp_len));
    check("writes_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Scoreboard monitor: compares every write strobe against the queue.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.we1 || bus.we2)) begin
        check("write_expected", {63'd0, exp_q.size() > 0}, 64'd1);
        check("we_pair", {62'd0, bus.we1, bus.we2}, 64'd3);
        check("ready_in_write", {63'd0, bus.in_ready}, 64'd0);
        if (exp_q.size() > 0) begin
          w = exp_q.pop_front();
          check("addr1", {32'd0, bus.addr1}, 64'(w.addr));
          check("addr2", {32'd0, bus.addr2}, 64'(w.addr));
          check("data1", {32'd0, bus.data1_in}, {32'd0, w.d1});
          check("data2", {32'd0, bus.data2_in}, {32'd0, w.d2});
        end
      end
    end
  end

  task automatic put_sp(input int mn);
    int n;
    n = $urandom_range(mn, mn + 2);
    for (int i = 0; i < n; i++) stim.push_back(($urandom_range(0, 2) == 0) ? 8'h09 : 8'h20);
  endtask

  task automatic put_num(input longint unsigned v);
    logic [7:0] d[$];
    longint unsigned t;
    t = v;
    if ($urandom_range(0, 5) == 0) stim.push_back(8'h30);
    do begin
      d.push_front(8'h30 + 8'(t % 10));
      t = t / 10;
    end while (t != 0);
    foreach (d[i]) stim.push_back(d[i]);
  endtask

  function automatic longint unsigned rand_val();
    longint unsigned v;
    case ($urandom_range(0, 3))
      0: v = longint'($urandom_range(0, 99));
      1: v = longint'($urandom);
      2: v = MAXV;
      default: v = longint'($urandom_range(0, 9));
    endcase
    return v;
  endfunction

  task automatic gen_random();
    int nl, kind;
    logic [7:0] badc[4];
    badc[0] = 8'h41; badc[1] = 8'h2C; badc[2] = 8'h2D; badc[3] = 8'h0B;
    stim.delete();
    nl = $urandom_range(1, 3);
    for (int l = 0; l < nl; l++) begin
      kind = $urandom_range(0, 11);
      if ($urandom_range(0, 3) == 0) put_sp(1);
      case (kind)
        0: put_sp(0);
        1: begin put_num(rand_val()); put_sp(1); stim.push_back(badc[$urandom_range(0, 3)]); end
        2: begin put_num(rand_val()); if ($urandom_range(0, 1) == 1) put_sp(1); end
        3: begin put_num(rand_val()); put_sp(1); put_num(rand_val()); put_sp(1); put_num(rand_val()); end
        4: begin put_num(MAXV + 1 + longint'($urandom_range(0, 5000))); put_sp(1); put_num(rand_val()); end
        default: begin put_num(rand_val()); put_sp(1); put_num(rand_val()); end
      endcase
      if ($urandom_range(0, 2) == 0) put_sp(1);
      if ($urandom_range(0, 3) == 0) stim.push_back(8'h0D);
      if (!(l == nl - 1 && $urandom_range(0, 2) == 0)) stim.push_back(8'h0A);
    end
    if (stim.size() == 0) stim.push_back(8'h0A);
  endtask

  initial begin
    bit ok;
    bus.go = 1'b0; bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.in_last = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_done",     {63'd0, bus.done},     64'd0);
    check("rst_length",   {48'd0, bus.length},   64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    load_str("3   4\n4   3\n");
    run_stream();
    check("done_latency", 64'(done_lat), 64'd2);

    load_str("10 20");
    run_stream();

    load_str("\n\n7 8\r\n");
    run_stream();

    load_str("4294967295 1\n");
    run_stream();
    load_str("4294967296 1\n");
    run_stream();

    load_str("5 x\n");
    run_stream();
    bus.in_data = 8'h31; bus.in_valid = 1'b1;
    @(negedge clk);
    check("err_in_ready", {63'd0, bus.in_ready}, 64'd0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;

    load_str("1 2\n3 4\n5 6\n");
    run_stream();

    // Reset in the middle of a line.
    load_str("12 3");
    pulse_go();
    for (int i = 0; i < stim.size(); i++) send_byte(stim[i], 1'b0, ok);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
    check("mid_rst_we",    {62'd0, bus.we1, bus.we2}, 64'd0);
    check("mid_rst_stat",  {62'd0, bus.done, bus.error}, 64'd0);
    check("mid_rst_len",   {48'd0, bus.length}, 64'd0);
    check("mid_rst_addr",  {32'd0, bus.addr1}, 64'd0);
    check("mid_rst_data",  {bus.data1_in, bus.data2_in}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk); #1;

    for (int t = 0; t < 40; t++) begin
      gen_random();
      run_stream();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
